// File: rtl/gate_truth_table_sequencer_if.sv
// Handshake/bus bundle between the truth-table sequencer, the board key/tick
// logic and the gate datapath.
//   i_start, i_step_mode, i_step, i_tick, i_func_sel : board controls
//   i_dut_result                                     : datapath output
//   o_dut_abc, o_dut_en                              : datapath drive
//   o_vec_idx, o_truth_table, o_busy, o_done, o_pass : status / LEDs
// The slave modport is the sequencer; master is the board/datapath side.
interface gate_truth_table_sequencer_if;
    logic       i_start;
    logic       i_step_mode;
    logic       i_step;
    logic       i_tick;
    logic [2:0] i_func_sel;
    logic       i_dut_result;
    logic [2:0] o_dut_abc;
    logic       o_dut_en;
    logic [2:0] o_vec_idx;
    logic [7:0] o_truth_table;
    logic       o_busy;
    logic       o_done;
    logic       o_pass;

    modport master (
        output i_start,
        output i_step_mode,
        output i_step,
        output i_tick,
        output i_func_sel,
        output i_dut_result,
        input  o_dut_abc,
        input  o_dut_en,
        input  o_vec_idx,
        input  o_truth_table,
        input  o_busy,
        input  o_done,
        input  o_pass
    );

    modport slave (
        input  i_start,
        input  i_step_mode,
        input  i_step,
        input  i_tick,
        input  i_func_sel,
        input  i_dut_result,
        output o_dut_abc,
        output o_dut_en,
        output o_vec_idx,
        output o_truth_table,
        output o_busy,
        output o_done,
        output o_pass
    );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Sweeps a 3-input gate datapath through all 8 vectors, samples each result
// into an 8-bit truth table and compares it against a golden mask.
// Ports:
//   i_clock : system clock
//   i_reset : synchronous active-low reset
//   bus     : gate_truth_table_sequencer_if.slave (controls, datapath, status)
// Parameters:
//   SETTLE_CYCLES : cycles a vector is held before sampling (>= 1)
//   DWELL_TICKS   : tick pulses per vector in run mode (>= 1)
// Optional: define GATE_SEQ_MISMATCH_STOP_EN to end the sweep at the first
// sampled bit that disagrees with the golden mask.
module gate_truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_TICKS   = 2
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    gate_truth_table_sequencer_if.slave   bus
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_settle_cnt;
    logic [TW-1:0] r_tick_cnt;
    logic [2:0]    r_vec_idx;
    logic [2:0]    r_func;
    logic [7:0]    r_truth;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_start_prev;
    logic          r_step_prev;

    logic          w_start_edge;
    logic          w_step_edge;
    logic          w_tick_last;
    logic          w_advance;
    logic [7:0]    w_golden;

    function automatic logic [7:0] golden_mask(input logic [2:0] f);
        logic [7:0] m;
        case (f)
            3'd0:    m = 8'hC0;
            3'd1:    m = 8'hFC;
            3'd2:    m = 8'h3C;
            3'd3:    m = 8'h3F;
            3'd4:    m = 8'h03;
            3'd5:    m = 8'hE8;
            3'd6:    m = 8'h16;
            default: m = 8'h96;
        endcase
        return m;
    endfunction

    assign w_start_edge = bus.i_start & ~r_start_prev;
    assign w_step_edge  = bus.i_step & ~r_step_prev;
    assign w_tick_last  = (r_tick_cnt == TW'(DWELL_TICKS - 1));
    assign w_golden     = golden_mask(r_func);

    // step_mode is read live so a mode switch mid-dwell acts at once;
    // the tick count is kept across the switch.
    assign w_advance = bus.i_step_mode ? w_step_edge
                                       : (bus.i_tick & w_tick_last);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_tick_cnt   <= '0;
            r_vec_idx    <= '0;
            r_func       <= '0;
            r_truth      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_start_prev <= 1'b0;
            r_step_prev  <= 1'b0;
        end else begin
            r_start_prev <= bus.i_start;
            r_step_prev  <= bus.i_step;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
                        r_tick_cnt   <= '0;
                        r_vec_idx    <= '0;
                        r_func       <= bus.i_func_sel;
                        r_truth      <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end

                S_SAMPLE: begin
                    r_truth[r_vec_idx] <= bus.i_dut_result;
                    r_tick_cnt         <= '0;
`ifdef GATE_SEQ_MISMATCH_STOP_EN
                    // Early exit: the failing index stays visible on
                    // vec_idx and higher table bits stay clear.
                    if (bus.i_dut_result != w_golden[r_vec_idx]) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                    end else begin
                        r_state <= S_DWELL;
                    end
`else
                    r_state <= S_DWELL;
`endif
                end

                S_DWELL: begin
                    if (w_advance) begin
                        if (r_vec_idx == 3'd7) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_truth == w_golden);
                        end else begin
                            r_state      <= S_SETTLE;
                            r_vec_idx    <= r_vec_idx + 3'd1;
                            r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
                        end
                    end else if (!bus.i_step_mode && bus.i_tick) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_dut_abc     = r_vec_idx;
    assign bus.o_dut_en      = r_busy;
    assign bus.o_vec_idx     = r_vec_idx;
    assign bus.o_truth_table = r_truth;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_pass        = r_pass;

endmodule
